// File: rtl/cntr_pkg.sv
// Shared definitions for the tile's counter blocks: timer state encodings and default widths.
package cntr_pkg;
    localparam int DEF_COUNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2
    } tmr_state_t;
endpackage

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / periodic reload and a registered expiry pulse.
module down_timer
    import cntr_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic                   auto_reload,
    input  logic                   start,
    input  logic                   stop,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done
);

    tmr_state_t             state;
    logic [COUNT_WIDTH-1:0] reload;

    // Decoded straight from the state flop, so no input reaches an output combinationally.
    assign load_ready = (state != ST_RUN);
    assign busy       = (state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        reload <= load_val;
                        count  <= load_val;
                        state  <= ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    if (load_valid) begin
                        reload <= load_val;
                        count  <= load_val;
                    end
                    if (start && !stop)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    // stop outranks the tick, including an expiring one
                    if (stop) begin
                        state <= ST_LOADED;
                    end else if (ena) begin
                        if (count != '0) begin
                            count <= count - 1'b1;
                        end else begin
                            done <= 1'b1;
                            if (auto_reload)
                                count <= reload;
                            else
                                state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Randomized + directed bench for down_timer against a behavioural timer model.
module tb_down_timer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena, load_valid, auto_reload, start, stop;
    logic [W-1:0] load_val;
    logic         load_ready, busy, done;
    logic [W-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    down_timer #(.COUNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .load_valid(load_valid), .load_ready(load_ready), .load_val(load_val),
        .auto_reload(auto_reload), .start(start), .stop(stop),
        .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural model: "running" and "has a period" flags plus integer count/period.
    bit m_run, m_have, m_done, was_have;
    int m_cnt, m_per;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_have = 0; m_done = 0; m_cnt = 0; m_per = 0;
        end else begin
            m_done = 0;
            if (m_run) begin
                if (stop) begin
                    m_run = 0;
                end else if (ena) begin
                    if (m_cnt > 0) begin
                        m_cnt = m_cnt - 1;
                    end else begin
                        m_done = 1;
                        if (auto_reload) m_cnt = m_per;
                        else begin m_run = 0; m_have = 0; end
                    end
                end
            end else begin
                was_have = m_have;
                if (load_valid) begin
                    m_per = int'(load_val); m_cnt = int'(load_val); m_have = 1;
                end
                if (was_have && start && !stop) m_run = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("count",      int'(count),      m_cnt);
            chk("busy",       int'(busy),       int'(m_run));
            chk("done",       int'(done),       int'(m_done));
            chk("load_ready", int'(load_ready), int'(!m_run));
        end
    end

    // Apply one cycle of inputs and return at the following negedge.
    task automatic step(input bit lv, input int lval, input bit st, input bit sp,
                        input bit en, input bit ar);
        load_valid = lv; load_val = W'(lval); start = st; stop = sp;
        ena = en; auto_reload = ar;
        @(negedge clk);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; ena = 0; load_valid = 0; load_val = '0;
        auto_reload = 0; start = 0; stop = 0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(load_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // One-shot load 3
        step(1, 3, 0, 0, 0, 0);  chk("t2_loaded", int'(count), 3);
        step(0, 0, 1, 0, 1, 0);  chk("t2_run", int'(busy), 1); chk("t2_c3", int'(count), 3);
        step(0, 0, 0, 0, 1, 0);  chk("t2_c2", int'(count), 2);
        step(0, 0, 0, 0, 1, 0);  chk("t2_c1", int'(count), 1);
        step(0, 0, 0, 0, 1, 0);  chk("t2_c0", int'(count), 0); chk("t2_nodone", int'(done), 0);
        step(0, 0, 0, 0, 1, 0);  chk("t2_done", int'(done), 1); chk("t2_busy0", int'(busy), 0);
        step(0, 0, 0, 0, 1, 0);  chk("t2_pulse", int'(done), 0); chk("t2_idle0", int'(count), 0);
        // start in IDLE is ignored
        step(0, 0, 1, 0, 1, 0);  chk("t2_idle_start", int'(busy), 0);

        // Periodic load 2
        step(1, 2, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 1);  chk("t3_c2", int'(count), 2);
        step(0, 0, 0, 0, 1, 1);  chk("t3_c1", int'(count), 1);
        step(0, 0, 0, 0, 1, 1);  chk("t3_c0", int'(count), 0);
        step(0, 0, 0, 0, 1, 1);  chk("t3_reload", int'(count), 2); chk("t3_done", int'(done), 1);
        chk("t3_busy", int'(busy), 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1);
        chk("t3_done2", int'(done), 1);
        step(0, 0, 0, 1, 1, 1);  chk("t3_stopped", int'(busy), 0);

        // Sparse ena, load 1 (reload into LOADED)
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);  chk("t4_c1", int'(count), 1);
        step(0, 0, 0, 0, 1, 0);  chk("t4_c0", int'(count), 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);  chk("t4_hold", int'(done), 0); chk("t4_busy", int'(busy), 1);
        step(0, 0, 0, 0, 1, 0);  chk("t4_done", int'(done), 1);

        // Stop / resume, load 9, then reset mid-run
        step(1, 9, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        chk("t5_c5", int'(count), 5);
        step(0, 0, 1, 1, 1, 0);  chk("t5_held", int'(count), 5); chk("t5_ready", int'(load_ready), 1);
        step(0, 0, 1, 0, 1, 0);  chk("t5_resume", int'(count), 5);
        step(0, 0, 0, 0, 1, 0);  chk("t5_c4", int'(count), 4);
        // load attempt during RUN
        step(1, 7, 0, 0, 0, 0);  chk("t6_noload", int'(count), 4); chk("t6_ready0", int'(load_ready), 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);  chk("t5_startstop", int'(busy), 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);  chk("t1_c2", int'(count), 2);
        for (int i = 0; i < 3; i++) step(1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 9, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);  chk("t1_c6", int'(count), 6);
        #2 rst = 1'b1;
        #1;
        chk("t1_count", int'(count), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_done", int'(done), 0);
        chk("t1_ready", int'(load_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Load 0 with simultaneous start from LOADED, then load 15
        step(1, 4, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);  chk("t6_z_run", int'(busy), 1); chk("t6_z_c0", int'(count), 0);
        step(0, 0, 0, 0, 1, 0);  chk("t6_z_done", int'(done), 1);
        // load+start in IDLE only loads
        step(1, 15, 1, 0, 0, 0); chk("t6_idle_ls", int'(busy), 0); chk("t6_c15", int'(count), 15);
        step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 1, 0);
        chk("t6_c0", int'(count), 0); chk("t6_nodone", int'(done), 0);
        step(0, 0, 0, 0, 1, 0);  chk("t6_done16", int'(done), 1);

        // Expiring tick with stop: stop wins
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1);  chk("stop_exp_done", int'(done), 0); chk("stop_exp_busy", int'(busy), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 chk("rnd_rst_count", int'(count), 0);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        idle_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
